// File: rtl/upsampler_pkg.sv
// Shared helpers for the upsampler: phase-width function, default sizes and the sync error classes.
package upsampler_pkg;

    localparam int unsigned DEFAULT_DW     = 16;
    localparam int unsigned DEFAULT_FACTOR = 8;

    typedef enum logic [1:0] {
        SYNC_NONE    = 2'd0,
        SYNC_EARLY   = 2'd1,
        SYNC_MISSING = 2'd2
    } sync_err_e;

    // Phase counter width for a power-of-two upsample ratio.
    function automatic int unsigned phase_w(input int unsigned factor);
        return $clog2(factor);
    endfunction

endpackage

// File: rtl/upsampler_lerp.sv
// Combinational interpolator between two low-rate samples at phase p/2^S.
// UPSAMPLER_LINEAR_EN selects linear interpolation; otherwise zero-order hold on prev.
module upsampler_lerp #(
    parameter int unsigned DW = 16,
    parameter int unsigned S  = 3
) (
    input  logic [DW-1:0] prev,
    input  logic [DW-1:0] cur,
    input  logic [S-1:0]  phase,
    output logic [DW-1:0] lerp_c
);

`ifdef UPSAMPLER_LINEAR_EN
    localparam int unsigned DIFF_W = DW + 1;
    localparam int unsigned PROD_W = DW + 1 + S;

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;
    logic                     unused_sum_hi;

    // Floor-rounded step keeps the result between prev and cur, so the DW-bit truncation never wraps.
    always_comb begin
        diff   = DIFF_W'($signed(cur)) - DIFF_W'($signed(prev));
        prod   = PROD_W'(diff) * $signed(PROD_W'({1'b0, phase}));
        sum    = PROD_W'($signed(prev)) + (prod >>> S);
        lerp_c = sum[DW-1:0];
    end

    assign unused_sum_hi = ^sum[PROD_W-1:DW];
`else
    logic unused_zoh;

    assign lerp_c     = prev;
    assign unused_zoh = ^{cur, phase};
`endif

endmodule

// File: rtl/upsampler.sv
// Interpolating upsampler: one low-rate sample per FACTOR high-rate ticks in, one sample per tick out.
// Build option: UPSAMPLER_LINEAR_EN enables linear interpolation (default is zero-order hold).
module upsampler
    import upsampler_pkg::*;
#(
    parameter int unsigned DW     = DEFAULT_DW,
    parameter int unsigned FACTOR = DEFAULT_FACTOR
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] data_i,
    input  logic          low_tick_i,
    input  logic          sample_tick_i,
    output logic [DW-1:0] data_o,
    output logic          data_valid_o,
    output logic          sync_err_o
);

    localparam int unsigned S    = phase_w(FACTOR);
    localparam logic [S-1:0] LAST = S'(FACTOR - 1);

    logic [DW-1:0] prev_q, cur_q;
    logic [S-1:0]  phase_q;
    logic          armed_q;
    logic          held_q;

    logic [DW-1:0] prev_n, cur_n, data_n, lerp_c;
    logic [S-1:0]  phase_n, p_sel;
    logic          armed_n, held_n;
    sync_err_e     err_n;

    // held_q marks that the last phase (FACTOR-1) has already been emitted, so FACTOR ticks have elapsed.
    always_comb begin
        prev_n  = prev_q;
        cur_n   = cur_q;
        phase_n = phase_q;
        armed_n = armed_q;
        held_n  = held_q;
        p_sel   = '0;
        err_n   = SYNC_NONE;
        if (sample_tick_i) begin
            if (low_tick_i) begin
                prev_n  = cur_q;
                cur_n   = data_i;
                phase_n = S'(1);
                held_n  = 1'b0;
                armed_n = 1'b1;
                if (armed_q && !((phase_q == LAST) && held_q)) begin
                    err_n = SYNC_EARLY;
                end
            end else if (armed_q) begin
                p_sel = phase_q;
                if (phase_q == LAST) begin
                    held_n = 1'b1;
                    if (held_q) begin
                        err_n = SYNC_MISSING;
                    end
                end else begin
                    phase_n = phase_q + S'(1);
                end
            end
        end
    end

    upsampler_lerp #(
        .DW (DW),
        .S  (S)
    ) u_lerp (
        .prev   (prev_n),
        .cur    (cur_n),
        .phase  (p_sel),
        .lerp_c (lerp_c)
    );

    // A missing low tick freezes the stream at the newest sample.
    assign data_n = (err_n == SYNC_MISSING) ? cur_q : lerp_c;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q       <= '0;
            cur_q        <= '0;
            phase_q      <= '0;
            armed_q      <= 1'b0;
            held_q       <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            sync_err_o   <= 1'b0;
        end else begin
            prev_q       <= prev_n;
            cur_q        <= cur_n;
            phase_q      <= phase_n;
            armed_q      <= armed_n;
            held_q       <= held_n;
            data_valid_o <= sample_tick_i;
            sync_err_o   <= (err_n != SYNC_NONE);
            if (sample_tick_i) begin
                data_o <= data_n;
            end
        end
    end

endmodule

// File: tb/tb_upsampler.sv
// Directed bench for upsampler (FACTOR=8, DW=16); expectations follow the UPSAMPLER_LINEAR_EN build option.
module tb_upsampler;
    import upsampler_pkg::*;

    localparam bit LIN =
`ifdef UPSAMPLER_LINEAR_EN
        1'b1;
`else
        1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rst_n_i;
    logic        [15:0] data_i;
    logic               low_tick_i;
    logic               sample_tick_i;
    logic signed [15:0] data_o;
    logic               data_valid_o;
    logic               sync_err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    upsampler #(
        .DW     (16),
        .FACTOR (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .data_i        (data_i),
        .low_tick_i    (low_tick_i),
        .sample_tick_i (sample_tick_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .sync_err_o    (sync_err_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One high-rate tick; outputs sampled 1 time unit after the capturing edge.
    task automatic tick(input logic l, input int d, input bit do_chk, input int exp_d,
                        input sync_err_e exp_s, input string tag);
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        low_tick_i    = l;
        data_i        = 16'(d);
        @(posedge clk_i);
        #1;
        sample_tick_i = 1'b0;
        low_tick_i    = 1'b0;
        if (do_chk) begin
            check({tag, ".data"}, int'(data_o), exp_d);
            check({tag, ".valid"}, int'(data_valid_o), 1);
            check({tag, ".err"}, int'(sync_err_o), (exp_s != SYNC_NONE) ? 1 : 0);
        end
    endtask

    task automatic fill(input int n);
        repeat (n) tick(1'b0, 0, 1'b0, 0, SYNC_NONE, "fill");
    endtask

    initial begin
        rst_n_i       = 1'b0;
        data_i        = '0;
        low_tick_i    = 1'b0;
        sample_tick_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset.data", int'(data_o), 0);
        check("reset.valid", int'(data_valid_o), 0);
        check("reset.err", int'(sync_err_o), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Unarmed: zero output, no sync complaint
        tick(1'b0, 0, 1'b1, 0, SYNC_NONE, "prearm");
        tick(1'b1, 0, 1'b1, 0, SYNC_NONE, "arm");
        fill(7);

        // Ramp 0 -> 800
        tick(1'b1, 800, 1'b1, 0, SYNC_NONE, "ramp.L");
        for (int p = 1; p <= 7; p++)
            tick(1'b0, 0, 1'b1, LIN ? 100 * p : 0, SYNC_NONE, $sformatf("ramp.p%0d", p));
        tick(1'b1, 100, 1'b1, 800, SYNC_NONE, "ramp.next");
        fill(7);

        // Negative ramp 100 -> -100 with floor rounding
        tick(1'b1, -100, 1'b1, 100, SYNC_NONE, "neg.L");
        tick(1'b0, 0, 1'b1, LIN ? 75 : 100, SYNC_NONE, "neg.p1");
        fill(1);
        tick(1'b0, 0, 1'b1, LIN ? 25 : 100, SYNC_NONE, "neg.p3");
        fill(1);
        tick(1'b0, 0, 1'b1, LIN ? -25 : 100, SYNC_NONE, "neg.p5");
        fill(2);

        // Full-scale swing -32768 -> 32767
        tick(1'b1, -32768, 1'b1, -100, SYNC_NONE, "ext.lo");
        fill(7);
        tick(1'b1, 32767, 1'b1, -32768, SYNC_NONE, "ext.L");
        tick(1'b0, 0, 1'b1, LIN ? -24577 : -32768, SYNC_NONE, "ext.p1");
        fill(2);
        tick(1'b0, 0, 1'b1, LIN ? -1 : -32768, SYNC_NONE, "ext.p4");
        fill(2);
        tick(1'b0, 0, 1'b1, LIN ? 24575 : -32768, SYNC_NONE, "ext.p7");

        // Early low tick after 5 ticks
        tick(1'b1, 0, 1'b1, 32767, SYNC_NONE, "early.pre");
        fill(4);
        tick(1'b1, 800, 1'b1, 0, SYNC_EARLY, "early.L");
        tick(1'b0, 0, 1'b1, LIN ? 100 : 0, SYNC_NONE, "early.p1");
        fill(6);

        // Low tick withheld 3 ticks
        for (int k = 0; k < 3; k++)
            tick(1'b0, 0, 1'b1, 800, SYNC_MISSING, $sformatf("miss%0d", k));
        tick(1'b1, 0, 1'b1, 800, SYNC_NONE, "miss.recover");
        tick(1'b0, 0, 1'b1, LIN ? 700 : 800, SYNC_NONE, "recover.p1");

        // Stray low tick without sample tick is ignored
        @(negedge clk_i);
        low_tick_i = 1'b1;
        data_i     = 16'd1234;
        @(posedge clk_i);
        #1;
        low_tick_i = 1'b0;
        check("stray.valid", int'(data_valid_o), 0);
        check("stray.err", int'(sync_err_o), 0);
        check("stray.data", int'(data_o), LIN ? 700 : 800);
        tick(1'b0, 0, 1'b1, LIN ? 600 : 800, SYNC_NONE, "stray.p2");

        // Asynchronous reset between clock edges
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst.data", int'(data_o), 0);
        check("arst.valid", int'(data_valid_o), 0);
        check("arst.err", int'(sync_err_o), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick(1'b1, 800, 1'b1, 0, SYNC_NONE, "rst.L");
        tick(1'b0, 0, 1'b1, LIN ? 100 : 0, SYNC_NONE, "rst.p1");

        @(posedge clk_i);
        #1;
        check("idle.valid", int'(data_valid_o), 0);
        check("idle.data", int'(data_o), LIN ? 100 : 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
